uart_tx_fifo_serializer: RTL and testbench
==========================================

# uart_tx_fifo_serializer

Read-domain consumer of the UART system's asynchronous TX FIFO. It watches the FIFO empty flag, pops one word at a time through the FIFO read-increment strobe, and serializes each word onto the UART line. The frame is start bit, data LSB first, optional parity, then stop bit. It runs entirely in the FIFO read clock domain, one line bit per clock (the TX bit-rate clock).

## Interface
- DATA_WD, 8, data bits per frame and FIFO word width

- CLK  in  1  read-domain / TX bit clock; all logic on rising edge
- RST  in  1  synchronous, active-low reset
- FIFO_EMPTY  in  1  FIFO empty flag (read domain)
- FIFO_RD_DATA  in  DATA_WD  word at current FIFO read address; valid whenever FIFO_EMPTY=0
- FIFO_R_INC  out  1  pop strobe to FIFO read side; one-cycle pulse per word consumed
- PAR_TYP  in  1  parity type, 0=even, 1=odd; ignored unless parity compiled in
- TX_OUT  out  1  serial line, idle high
- BUSY  out  1  high while a frame (start..stop) is on the line

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Load condition: (state IDLE or STOP) and FIFO_EMPTY=0.
  - FIFO_R_INC = load condition and RST=1 (combinational).
  - On the same edge, FIFO_RD_DATA is latched into the shift register and PAR_TYP into a parity-type flag.
  - Next state is START.
- IDLE with FIFO_EMPTY=1: stay in IDLE, TX_OUT=1, BUSY=0, FIFO_R_INC=0.
- START: line 0 for one cycle, then DATA.
- DATA: DATA_WD cycles. A bit counter of width clog2(DATA_WD) starts at 0 and sends shift-register bit[counter], LSB first. Leave DATA when counter = DATA_WD-1 and reset the counter to 0.
- DATA exit goes to PARITY (parity built) or STOP (parity not built).
- PARITY: one cycle. Value = XOR of latched word, XOR the latched parity-type flag.
- STOP: line 1 for one cycle.
  - If the load condition holds, pop and go to START: back-to-back frames, no idle gap.
  - Otherwise go to IDLE.
- No pop occurs outside IDLE/STOP. FIFO_EMPTY changes mid-frame have no effect on the frame in flight.
- TX_OUT and BUSY are registered: driven from the next-state decode so the output is glitch-free. The START level appears in the cycle after the pop.

## Timing
- Reset (RST=0 at an edge): state IDLE, TX_OUT=1, BUSY=0, counter 0, shift register 0. FIFO_R_INC is forced 0 while RST=0.
- Reset mid-frame: the line returns to 1 on the next edge. The partially sent word is discarded, not re-popped.
- Pop in cycle N gives TX_OUT=0 and BUSY=1 in cycle N+1.
- Data bits occupy N+2..N+1+DATA_WD. Parity, when built, occupies N+2+DATA_WD. Stop follows.
- Frame length: DATA_WD+2 cycles without parity, DATA_WD+3 with parity.
- Back-to-back: the next START immediately follows STOP, with BUSY held 1 throughout.
- BUSY falls in the cycle after the final STOP when no word is pending.
- Exactly one FIFO_R_INC pulse per frame. The pulse never occurs while FIFO_EMPTY=1.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state exists.
  - The parity bit is inserted after the data bits.
  - PAR_TYP is sampled at load.
- UART_TX_PARITY_EN undefined:
  - No PARITY state; DATA goes directly to STOP.
  - PAR_TYP is unused, but the port is kept so the port list is identical in both builds.

## Test plan
- Reset: hold RST=0 for 3 cycles with FIFO_EMPTY=0 -> FIFO_R_INC=0, TX_OUT=1, BUSY=0 throughout.
- Single word 0xA5, parity built, PAR_TYP=0, pop at cycle N:
  - TX_OUT from N+1 = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, even parity 0, stop).
  - Then IDLE with BUSY=0.
  - Same word with PAR_TYP=1 -> parity bit 1.
- Back-to-back 0x01 then 0xFF (parity not built): exactly 2 pops, 10 cycles apart. TX_OUT = 0,1,0,0,0,0,0,0,0,1,0,1,1,1,1,1,1,1,1,1 with no gap, and BUSY held 1 for 20 cycles.
- Empty FIFO: FIFO_EMPTY=1 for 50 cycles -> no pops, TX_OUT=1.
  - FIFO_EMPTY toggling during a frame -> no extra pop, frame unchanged.
- Reset at the 4th data bit of 0x3C -> TX_OUT=1 and BUSY=0 the next cycle.
  - After RST release with FIFO_EMPTY=0 -> new pop one cycle later, new frame starts cleanly.
- Scoreboard: 16 random words pushed through the async FIFO model -> the decoded line data matches the push order and the pop count is 16.

Source files
------------

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmitter fed from the read side of the TX FIFO: start, data LSB first,
// optional parity (build with UART_TX_PARITY_EN), stop. One line bit per CLK.
module uart_tx_fifo_serializer #(
  parameter int DATA_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FIFO_EMPTY,
  input  logic [DATA_WD-1:0] FIFO_RD_DATA,
  output logic               FIFO_R_INC,
  input  logic               PAR_TYP,
  output logic               TX_OUT,
  output logic               BUSY
);

  localparam int CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_WD-1:0] shift_q, shift_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               par_typ_q, par_typ_d;
  logic               load;

  // A new word may only be taken while the line is idle or showing the stop bit.
  assign load       = ((state_q == IDLE) || (state_q == STOP)) && !FIFO_EMPTY;
  assign FIFO_R_INC = load && RST;

`ifndef UART_TX_PARITY_EN
  logic unused_par_typ;
  assign unused_par_typ = PAR_TYP ^ par_typ_q;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;

    case (state_q)
      IDLE, STOP: begin
        if (load) begin
          state_d   = START;
          shift_d   = FIFO_RD_DATA;
`ifdef UART_TX_PARITY_EN
          par_typ_d = PAR_TYP;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = STOP;
`endif
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the upcoming state so TX_OUT comes straight off a flop.
    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_q[cnt_d];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = (^shift_q) ^ par_typ_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Bench for uart_tx_fifo_serializer: a frame-level line model checked every cycle,
// plus literal line patterns for directed words. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo_serializer;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = DW + 2 + (PAR ? 1 : 0);

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_r_inc;
  logic          par_typ;
  logic          tx_out;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx_fifo_serializer #(.DATA_WD(DW)) dut (
    .CLK          (clk),
    .RST          (rst),
    .FIFO_EMPTY   (fifo_empty),
    .FIFO_RD_DATA (fifo_rd_data),
    .FIFO_R_INC   (fifo_r_inc),
    .PAR_TYP      (par_typ),
    .TX_OUT       (tx_out),
    .BUSY         (busy)
  );

  int            checks = 0;
  int            errors = 0;
  int            pops   = 0;
  int            cyc    = 0;
  bit            force_empty = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic          model_q[$];
  logic          cap_tx[$];
  logic          cap_busy[$];
  int            pop_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole frame as the line must show it, one entry per cycle.
  function automatic void push_frame(input logic [DW-1:0] w, input logic pt);
    model_q.push_back(1'b0);
    for (int b = 0; b < DW; b++) model_q.push_back(w[b]);
    if (PAR) model_q.push_back((^w) ^ pt);
    model_q.push_back(1'b1);
  endfunction

  task automatic tick();
    logic          exp_pop;
    logic          seen_pop;
    logic [DW-1:0] w;
    logic          pt;
    fifo_empty   = (fifo_q.size() == 0) || force_empty;
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    exp_pop = rst && !fifo_empty && (model_q.size() <= 1);
    chk("fifo_r_inc", fifo_r_inc, exp_pop);
    seen_pop = fifo_r_inc;
    w        = fifo_rd_data;
    pt       = par_typ;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      if (exp_pop) push_frame(w, pt);
    end
    if (seen_pop === 1'b1) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
      pop_cyc.push_back(cyc);
      $display("txn: pop word 0x%02h par_typ %0d at cycle %0d", w, pt, cyc - 1);
    end
    chk("tx_out", tx_out, (model_q.size() != 0) ? model_q[0] : 1'b1);
    chk("busy", busy, model_q.size() != 0);
    cap_tx.push_back(tx_out);
    cap_busy.push_back(busy);
  endtask

  task automatic run_single(input string nm, input logic [DW-1:0] w, input logic pt,
                            input logic [31:0] exp_line);
    int          p0;
    logic [31:0] got;
    par_typ = pt;
    fifo_q.push_back(w);
    p0 = pops;
    cap_tx.delete();
    cap_busy.delete();
    tick();
    chk({nm, "_pop"}, pops - p0, 1);
    repeat (FL + 1) tick();
    got = '0;
    for (int k = 0; k < FL; k++) got[k] = cap_tx[k];
    chk({nm, "_line"}, got, exp_line);
    chk({nm, "_busy_after"}, cap_busy[FL], 1'b0);
    chk({nm, "_pop_total"}, pops - p0, 1);
  endtask

  initial begin
    logic [31:0]   exp_a_even, exp_a_odd, exp_b2b, got;
    logic [DW-1:0] sent[$];
    logic [DW-1:0] d;
    int            p0, n, i, k;

`ifdef UART_TX_PARITY_EN
    exp_a_even = 32'b10100101010;
    exp_a_odd  = 32'b11100101010;
    exp_b2b    = 32'b10111111110_11000000010;
`else
    exp_a_even = 32'b1101001010;
    exp_a_odd  = 32'b1101001010;
    exp_b2b    = 32'b1111111110_1000000010;
`endif

    rst          = 1'b0;
    par_typ      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;

    // Reset with a word waiting: no pop, idle line.
    fifo_q.push_back(8'h11);
    p0 = pops;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rst_tx", tx_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    chk("rst_no_pop", pops - p0, 0);
    fifo_q.delete();
    rst = 1'b1;
    repeat (2) tick();

    run_single("a5_even", 8'hA5, 1'b0, exp_a_even);
    run_single("a5_odd", 8'hA5, 1'b1, exp_a_odd);

    // Back-to-back frames.
    par_typ = 1'b0;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hFF);
    p0 = pops;
    cap_tx.delete();
    cap_busy.delete();
    repeat (2 * FL + 2) tick();
    chk("b2b_pops", pops - p0, 2);
    if (pop_cyc.size() >= 2)
      chk("b2b_pop_gap", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], FL);
    got = '0;
    for (int j = 0; j < 2 * FL; j++) got[j] = cap_tx[j];
    chk("b2b_line", got, exp_b2b);
    got = '0;
    for (int j = 0; j < 2 * FL; j++) got[j] = cap_busy[j];
    chk("b2b_busy_held", got, (32'd1 << (2 * FL)) - 1);
    chk("b2b_busy_fall", cap_busy[2*FL], 1'b0);

    // Empty FIFO for 50 cycles.
    p0 = pops;
    for (int j = 0; j < 50; j++) begin
      tick();
      chk("empty_tx", tx_out, 1'b1);
    end
    chk("empty_no_pop", pops - p0, 0);

    // FIFO_EMPTY toggling while a frame is in flight.
    fifo_q.push_back(8'h96);
    p0 = pops;
    tick();
    fifo_q.push_back(8'h3E);
    for (int j = 1; j < FL; j++) begin
      force_empty = j[0];
      tick();
    end
    chk("toggle_one_pop", pops - p0, 1);
    force_empty = 1'b0;
    repeat (FL + 2) tick();
    chk("toggle_second_pop", pops - p0, 2);

    // Reset during the 4th data bit of 0x3C.
    fifo_q.push_back(8'h3C);
    cap_tx.delete();
    cap_busy.delete();
    tick();
    repeat (4) tick();
    chk("mid_bit3", cap_tx[4], 1'b1);
    fifo_q.push_back(8'hC3);
    rst = 1'b0;
    p0  = pops;
    tick();
    chk("mid_rst_tx", tx_out, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_no_pop", pops - p0, 0);
    rst = 1'b1;
    tick();
    chk("mid_repop", pops - p0, 1);
    chk("mid_restart", tx_out, 1'b0);
    repeat (FL + 1) tick();
    chk("mid_idle", busy, 1'b0);

    // Random scoreboard of 16 words.
    par_typ = 1'b1;
    cap_tx.delete();
    cap_busy.delete();
    for (int j = 0; j < 16; j++) begin
      d = DW'($urandom_range(0, 255));
      sent.push_back(d);
      fifo_q.push_back(d);
    end
    p0 = pops;
    n  = 0;
    while (n < 16 * FL + 40 && !((pops - p0) == 16 && busy == 1'b0)) begin
      tick();
      n++;
    end
    chk("sb_in_time", n < 16 * FL + 40, 1'b1);
    chk("sb_pops", pops - p0, 16);
    i = 0;
    k = 0;
    while (i < cap_tx.size()) begin
      if (cap_tx[i] == 1'b0 && i + FL <= cap_tx.size()) begin
        for (int b = 0; b < DW; b++) d[b] = cap_tx[i + 1 + b];
        if (k < sent.size()) chk($sformatf("sb_word%0d", k), d, sent[k]);
        k++;
        i += FL;
      end else begin
        i++;
      end
    end
    chk("sb_count", k, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
